// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks in-flight register writes for the in-order pipeline and
//            produces the ID-stage stall plus the EX-stage forwarding selects.
//            The scoreboard is a shift chain: pos 0 = EX ... pos DEPTH-1 = WB.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int LAT_W = 2,
  parameter int SEL_W = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [AW-1:0]    id_rs_i,
  input  logic [AW-1:0]    id_rt_i,
  input  logic             id_rs_use_i,
  input  logic             id_rt_use_i,
  input  logic             id_we_i,
  input  logic [AW-1:0]    id_rd_i,
  input  logic [LAT_W-1:0] id_lat_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [SEL_W-1:0] fwd_rs_o,
  output logic [SEL_W-1:0] fwd_rt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Scoreboard entries {valid, rd, lat}; index = pipeline position.
  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][AW-1:0]    r_rd;
  logic [DEPTH-1:0][LAT_W-1:0] r_lat;

  logic [SEL_W-1:0] r_fwd_rs;
  logic [SEL_W-1:0] r_fwd_rt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_rs_haz;
  logic             w_rt_haz;
  logic [SEL_W-1:0] w_rs_sel;
  logic [SEL_W-1:0] w_rt_sel;
  logic             w_issue;
  logic             w_load;
  logic [LAT_W-1:0] w_lat_in;

  // Resolve each operand against the youngest matching entry; scanning from
  // the oldest position lets younger matches overwrite older ones.
  always_comb begin
    w_rs_haz = 1'b0;
    w_rt_haz = 1'b0;
    w_rs_sel = '0;
    w_rt_sel = '0;
    for (int p = DEPTH - 1; p >= 0; p--) begin
      if (id_rs_use_i && (id_rs_i != '0) && r_vld[p] && (r_rd[p] == id_rs_i)) begin
        w_rs_haz = ((p + 1) < int'(r_lat[p]));
        // The WB-stage writer reaches the regfile this cycle (write-through).
        w_rs_sel = (p == DEPTH - 1) ? '0 : SEL_W'(p + 1);
      end
      if (id_rt_use_i && (id_rt_i != '0) && r_vld[p] && (r_rd[p] == id_rt_i)) begin
        w_rt_haz = ((p + 1) < int'(r_lat[p]));
        w_rt_sel = (p == DEPTH - 1) ? '0 : SEL_W'(p + 1);
      end
    end
  end

  // Flush squashes the ID instruction, so it also masks any stall.
  assign stall_o  = id_valid_i && !flush_i && (w_rs_haz || w_rt_haz);
  assign w_issue  = id_valid_i && !flush_i && !stall_o;
  assign w_load   = w_issue && id_we_i && (id_rd_i != '0);
  // A zero latency is meaningless; store it as a one-stage latency.
  assign w_lat_in = (id_lat_i == '0) ? LAT_W'(1) : id_lat_i;

  // Advance the scoreboard one stage; pos 0 takes the new writer or a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld <= '0;
      r_rd  <= '0;
      r_lat <= '0;
    end else begin
      r_vld <= {r_vld[DEPTH-2:0], w_load};
      r_rd  <= {r_rd[DEPTH-2:0], id_rd_i};
      r_lat <= {r_lat[DEPTH-2:0], w_lat_in};
    end
  end

  // Forwarding selects follow the issued instruction into EX; bubbles get 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fwd_rs <= '0;
      r_fwd_rt <= '0;
    end else begin
      r_fwd_rs <= w_issue ? w_rs_sel : '0;
      r_fwd_rt <= w_issue ? w_rt_sel : '0;
    end
  end

  // Saturating count of stall cycles for performance measurement.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fwd_rs_o    = r_fwd_rs;
  assign fwd_rt_o    = r_fwd_rt;
  assign stall_cnt_o = r_stall_cnt;

  // A writer whose latency reaches past WB can never be forwarded.
  a_lat_legal: assert property (@(posedge clk_i) disable iff (!rst_i)
    (id_valid_i && id_we_i) |-> (int'(id_lat_i) < DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Scoreboard bench for hazard_scoreboard (DEPTH=3, CNT_W=4 so the
//            counter saturation is reachable). Expected values come from a
//            model of in-flight writes tracked by age since issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_rs_use_i;
  logic       id_rt_use_i;
  logic       id_we_i;
  logic [4:0] id_rd_i;
  logic [1:0] id_lat_i;
  logic       flush_i;
  logic       stall_o;
  logic [1:0] fwd_rs_o;
  logic [1:0] fwd_rt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  hazard_scoreboard #(
    .AW(5), .DEPTH(DEPTH), .LAT_W(2), .SEL_W(2), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_use_i(id_rs_use_i), .id_rt_use_i(id_rt_use_i),
    .id_we_i(id_we_i), .id_rd_i(id_rd_i), .id_lat_i(id_lat_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct { int stall; int frs; int frt; int cnt; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  exp_t mon_e;
  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall_o",     int'(stall_o),     mon_e.stall);
      chk("fwd_rs_o",    int'(fwd_rs_o),    mon_e.frs);
      chk("fwd_rt_o",    int'(fwd_rt_o),    mon_e.frt);
      chk("stall_cnt_o", int'(stall_cnt_o), mon_e.cnt);
    end
  end

  // ---------------- reference model ----------------
  // Each in-flight write remembers how many cycles ago it entered EX.
  typedef struct { logic [4:0] rd; int lat; int age; } ent_t;
  ent_t inflt[$];
  int   m_frs = 0;
  int   m_frt = 0;
  int   m_cnt = 0;
  bit   m_last_stall = 0;

  task automatic resolve(input logic [4:0] addr, input logic use_b,
                         output bit hz, output int sel);
    int best;
    best = -1;
    hz   = 0;
    sel  = 0;
    if (use_b && addr != 5'd0) begin
      foreach (inflt[i]) begin
        if (inflt[i].rd == addr && (best < 0 || inflt[i].age < inflt[best].age))
          best = i;
      end
    end
    if (best >= 0) begin
      hz  = (inflt[best].age + 1) < inflt[best].lat;
      sel = (inflt[best].age == DEPTH - 1) ? 0 : inflt[best].age + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic we,
                       input logic [4:0] rd, input logic [1:0] lat, input logic fl);
    id_valid_i = v;   id_rs_i = rs;      id_rt_i = rt;
    id_rs_use_i = rsu; id_rt_use_i = rtu; id_we_i = we;
    id_rd_i = rd;     id_lat_i = lat;    flush_i = fl;
  endtask

  // One normal pipeline cycle.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic rsu, input logic rtu, input logic we,
                     input logic [4:0] rd, input logic [1:0] lat, input logic fl);
    exp_t e;
    ent_t nq[$];
    ent_t ne;
    bit hrs, hrt, st, iss;
    int srs, srt;
    @(posedge clk); #1;
    rst_i = 1'b1;
    drive(v, rs, rt, rsu, rtu, we, rd, lat, fl);
    resolve(rs, rsu, hrs, srs);
    resolve(rt, rtu, hrt, srt);
    st  = v && !fl && (hrs || hrt);
    iss = v && !fl && !st;
    e.stall = int'(st); e.frs = m_frs; e.frt = m_frt; e.cnt = m_cnt;
    exp_q.push_back(e);
    foreach (inflt[i]) begin
      if (inflt[i].age + 1 <= DEPTH - 1) begin
        ne = inflt[i];
        ne.age = ne.age + 1;
        nq.push_back(ne);
      end
    end
    if (iss && we && rd != 5'd0) begin
      ne.rd = rd; ne.lat = (lat == 2'd0) ? 1 : int'(lat); ne.age = 0;
      nq.push_back(ne);
    end
    inflt = nq;
    m_frs = iss ? srs : 0;
    m_frt = iss ? srt : 0;
    if (st && m_cnt != CMAX) m_cnt++;
    m_last_stall = st;
  endtask

  // A cycle with reset asserted mid-cycle; outputs must clear at once.
  task automatic rst_cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    @(posedge clk); #1;
    drive(v, rs, rt, 1'b1, 1'b1, 1'b0, 5'd0, 2'd1, 1'b0);
    rst_i = 1'b0;
    inflt.delete();
    m_frs = 0; m_frt = 0; m_cnt = 0; m_last_stall = 0;
    e.stall = 0; e.frs = 0; e.frt = 0; e.cnt = 0;
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  logic       rv, rrsu, rrtu, rwe;
  logic [4:0] rrs, rrt, rrd;
  logic [1:0] rlat;

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd1, 1'b0);
    rst_cyc(1'b0, 5'd0, 5'd0);
    rst_cyc(1'b0, 5'd0, 5'd0);

    // add r3, then rs=r3 next cycle -> forward from EX/MEM
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 1, 0);
    // add r3, bubble, rt=r3 -> forward from MEM/WB
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 3, 0, 1, 0, 0, 1, 0);
    // lw r3 then rs=r3 -> one stall then forward 2
    cyc(1, 0, 0, 0, 0, 1, 3, 2, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 1, 0);
    // add r0 then rs=r0
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 1, 0);
    // add r5, two bubbles, rs=r5 -> writer in WB, regfile path
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 1, 0);
    // two add r5 back to back, both operands r5 -> youngest wins
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 0);
    cyc(1, 5, 5, 1, 1, 0, 0, 1, 0);
    // lw r3 hazard squashed by flush
    cyc(1, 0, 0, 0, 0, 1, 3, 2, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // latency 0 behaves as 1
    cyc(1, 0, 0, 0, 0, 1, 6, 0, 0);
    cyc(1, 6, 6, 1, 1, 0, 0, 1, 0);
    // reset while a load to r3 is pending, then r3 use does not stall
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 0);
    cyc(1, 3, 0, 1, 0, 1, 3, 2, 0);
    rst_cyc(1'b1, 5'd3, 5'd0);
    cyc(1, 3, 0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // randomized traffic; a stalled instruction is held in ID
    rv = 0; rrs = 0; rrt = 0; rrsu = 0; rrtu = 0; rwe = 0; rrd = 0; rlat = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_cyc(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end else begin
        if (!m_last_stall) begin
          rv   = ($urandom_range(0, 9) != 0);
          rrs  = 5'($urandom_range(0, 3));
          rrt  = 5'($urandom_range(0, 3));
          rrsu = 1'($urandom_range(0, 1));
          rrtu = 1'($urandom_range(0, 1));
          rwe  = ($urandom_range(0, 3) != 0);
          rrd  = 5'($urandom_range(0, 3));
          rlat = 2'($urandom_range(0, 2));
        end
        cyc(rv, rrs, rrt, rrsu, rrtu, rwe, rrd, rlat, ($urandom_range(0, 7) == 0));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order pipeline; generalises the fixed load-use hazard check to DEPTH post-ID stages and per-instruction result latency.
- Tracks every in-flight register write in a shift scoreboard (pos 0 = EX, pos 1 = MEM, …, pos DEPTH-1 = WB).
- Issues a combinational stall for the ID instruction, and registered forwarding selects aligned with the EX stage.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- AW, 5, register address width; register 0 is hardwired zero.
- DEPTH, 3, number of tracked stages after ID (EX..WB); legal range 2..8.
- LAT_W, 2, width of the latency field.
- SEL_W, $clog2(DEPTH), width of the forwarding selects.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  AW  rs address of the ID instruction.
- id_rt_i  in  AW  rt address of the ID instruction.
- id_rs_use_i  in  1  the ID instruction reads rs.
- id_rt_use_i  in  1  the ID instruction reads rt.
- id_we_i  in  1  the ID instruction writes a register.
- id_rd_i  in  AW  destination address, already RegDst-resolved.
- id_lat_i  in  LAT_W  stages after entering EX until the result is forwardable (ALU=1, load=2); legal range 1..DEPTH-1.
- flush_i  in  1  squash the ID instruction (taken branch/jump).
- stall_o  out  1  hold PC and IF/ID, insert bubble into EX; combinational.
- fwd_rs_o  out  SEL_W  EX-stage rs source: 0 = regfile, k = pipeline register at the output of stage pos k-1 (1 = EX/MEM, 2 = MEM/WB, …).
- fwd_rt_o  out  SEL_W  same encoding as fwd_rs_o, for rt.
- stall_cnt_o  out  CNT_W  count of stall cycles, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - all entries invalid;
  - fwd_rs_o=0, fwd_rt_o=0, stall_cnt_o=0;
  - stall_o=0 (it depends only on state and inputs).
- Reset mid-operation discards all in-flight entries immediately.
- Entry format: {valid, rd, lat}.
- Every clock, entries shift: pos p → p+1, and pos DEPTH-1 is dropped.
- Pos 0 loads the issued instruction when id_valid_i & id_we_i & rd≠0 & ~stall_o & ~flush_i; otherwise pos 0 loads a bubble (valid=0).
- Match for an operand:
  - use bit set, address ≠ 0, and some valid entry at pos p with rd equal to the address;
  - the youngest match (lowest p) is the only one considered.
- The youngest match at pos p is resolved as follows:
  - p+1 < lat: hazard;
  - p+1 ≥ lat and p+1 ≤ DEPTH-1: select = p+1;
  - p = DEPTH-1 (writing back this cycle): select = 0, because the regfile is write-through.
- stall_o = id_valid_i & ~flush_i & (rs hazard | rt hazard). Flush always overrides stall.
- fwd_rs_o / fwd_rt_o are registered at every clock edge:
  - computed select when the ID instruction issues;
  - 0 when a bubble is inserted (stall, flush, or id_valid_i=0).
- Latency of the selects is 1 cycle: they are valid while the consumer is in EX.
- stall_cnt_o increments on each cycle with stall_o=1 and holds at all-ones.
- Simultaneous rs and rt matches are resolved independently. A single stall covers both.
- id_lat_i=0 is treated as 1. id_lat_i ≥ DEPTH is illegal; behaviour is undefined and a simulation assertion flags it.

Test Plan (DEPTH=3):
- add r3 issued, next cycle ID reads rs=r3 → stall_o=0; following cycle fwd_rs_o=1.
- add r3, bubble, then ID reads rt=r3 → stall_o=0, fwd_rt_o=2.
- lw r3 (lat=2), then ID reads rs=r3:
  - stall_o=1 for exactly 1 cycle;
  - then issue with fwd_rs_o=2;
  - stall_cnt_o=1.
- add r0 then ID reads rs=r0 → stall_o=0, fwd_rs_o=0. add r5 three cycles earlier (pos 2) → fwd 0.
- add r5 at pos 1 and add r5 at pos 0, ID reads rs=r5 and rt=r5 → fwd_rs_o=fwd_rt_o=1 (youngest wins).
- lw r3 hazard with flush_i=1 in the same cycle → stall_o=0, a bubble issues, and stall_cnt_o is unchanged.
- rst_i pulsed low while a load is pending:
  - all outputs read 0 immediately;
  - the next use of r3 does not stall.
